// File: rtl/uart_echo.sv
// UART loopback: oversampled RX -> FIFO -> TX, with frame/overrun reporting.
// Optional even parity on both directions when UART_ECHO_PARITY_EN is defined.
module uart_echo #(
    parameter int DIV   = 4,
    parameter int OVS   = 5,
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       loop_en,
    output logic       tx,
    output logic [3:0] status,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW = $clog2(OVS + 1);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int AW = $clog2(DEPTH);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [OW-1:0] OS_LAST  = OW'(OVS - 1);
    localparam logic [OW-1:0] OS_HALF  = OW'(OVS / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_HALF = (AW + 1)'(DEPTH / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_ECHO_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic [DW-1:0]    r_div_cnt;
    logic             w_tick;
    logic             r_sync1, r_sync2;
    logic             w_rx_s;

    state_t           r_rx_state;
    logic [OW-1:0]    r_rx_cnt;
    logic [BW-1:0]    r_rx_bits;
    logic [WIDTH-1:0] r_rx_shift;
    logic             r_rx_prev;
    logic             r_wr_en;
    logic [WIDTH-1:0] r_wr_data;
    logic             r_frame_err;
    logic             w_par_bad;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_sticky;
    logic             r_overrun;
    logic             w_full, w_not_empty, w_push, w_pop;

    state_t           r_tx_state;
    logic [OW-1:0]    r_tx_cnt;
    logic [BW-1:0]    r_tx_bits;
    logic [WIDTH-1:0] r_tx_shift;
    logic             r_tx;

    assign w_tick = (r_div_cnt == DIV_LAST);

    // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            r_sync1   <= rx;
            r_sync2   <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

`ifdef UART_ECHO_PARITY_EN
    logic r_par_bad;
    assign w_par_bad = r_par_bad;
`else
    assign w_par_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state  <= S_IDLE;
            r_rx_cnt    <= '0;
            r_rx_bits   <= '0;
            r_rx_shift  <= '0;
            r_rx_prev   <= 1'b1;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
            r_frame_err <= 1'b0;
`ifdef UART_ECHO_PARITY_EN
            r_par_bad   <= 1'b0;
`endif
        end else begin
            r_wr_en     <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_tick) begin
                r_rx_prev <= w_rx_s;
                case (r_rx_state)
                    S_IDLE: if (r_rx_prev && !w_rx_s) begin
                        r_rx_state <= S_START;
                        r_rx_cnt   <= '0;
                    end
                    S_START: if (r_rx_cnt == OS_HALF) begin
                        r_rx_cnt   <= '0;
                        r_rx_bits  <= '0;
                        r_rx_state <= w_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                    S_DATA: if (r_rx_cnt == OS_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {w_rx_s, r_rx_shift[WIDTH-1:1]};
                        if (r_rx_bits == BIT_LAST) begin
`ifdef UART_ECHO_PARITY_EN
                            r_rx_state <= S_PARITY;
`else
                            r_rx_state <= S_STOP;
`endif
                        end else begin
                            r_rx_bits <= r_rx_bits + 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
`ifdef UART_ECHO_PARITY_EN
                    S_PARITY: if (r_rx_cnt == OS_LAST) begin
                        r_rx_cnt   <= '0;
                        r_par_bad  <= (w_rx_s != ^r_rx_shift);
                        r_rx_state <= S_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
`endif
                    S_STOP: if (r_rx_cnt == OS_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= S_IDLE;
                        if (!w_rx_s || w_par_bad) begin
                            r_frame_err <= 1'b1;
                        end else begin
                            r_wr_en   <= 1'b1;
                            r_wr_data <= r_rx_shift;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                    default: r_rx_state <= S_IDLE;
                endcase
            end
        end
    end

    assign w_full      = (r_count == CNT_FULL);
    assign w_not_empty = (r_count != '0);
    assign w_pop       = w_tick && (r_tx_state == S_IDLE) && loop_en && w_not_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push      = r_wr_en && (!w_full || w_pop);

    // NOTE: the storage array has no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_sticky  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            if (r_wr_en && !w_push) begin
                r_overrun <= 1'b1;
                r_sticky  <= 1'b1;
            end
        end
    end

`ifdef UART_ECHO_PARITY_EN
    logic r_tx_par;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bits  <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
`ifdef UART_ECHO_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else if (w_tick) begin
            case (r_tx_state)
                S_IDLE: if (w_pop) begin
                    r_tx_shift <= r_mem[r_rd_ptr];
`ifdef UART_ECHO_PARITY_EN
                    r_tx_par   <= ^r_mem[r_rd_ptr];
`endif
                    r_tx       <= 1'b0;
                    r_tx_cnt   <= '0;
                    r_tx_state <= S_START;
                end
                S_START: if (r_tx_cnt == OS_LAST) begin
                    r_tx_cnt   <= '0;
                    r_tx_bits  <= '0;
                    r_tx       <= r_tx_shift[0];
                    r_tx_state <= S_DATA;
                end else begin
                    r_tx_cnt <= r_tx_cnt + 1'b1;
                end
                S_DATA: if (r_tx_cnt == OS_LAST) begin
                    r_tx_cnt <= '0;
                    if (r_tx_bits == BIT_LAST) begin
`ifdef UART_ECHO_PARITY_EN
                        r_tx       <= r_tx_par;
                        r_tx_state <= S_PARITY;
`else
                        r_tx       <= 1'b1;
                        r_tx_state <= S_STOP;
`endif
                    end else begin
                        r_tx_bits  <= r_tx_bits + 1'b1;
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx       <= r_tx_shift[1];
                    end
                end else begin
                    r_tx_cnt <= r_tx_cnt + 1'b1;
                end
`ifdef UART_ECHO_PARITY_EN
                S_PARITY: if (r_tx_cnt == OS_LAST) begin
                    r_tx_cnt   <= '0;
                    r_tx       <= 1'b1;
                    r_tx_state <= S_STOP;
                end else begin
                    r_tx_cnt <= r_tx_cnt + 1'b1;
                end
`endif
                S_STOP: if (r_tx_cnt == OS_LAST) begin
                    r_tx_cnt   <= '0;
                    r_tx_state <= S_IDLE;
                end else begin
                    r_tx_cnt <= r_tx_cnt + 1'b1;
                end
                default: r_tx_state <= S_IDLE;
            endcase
        end
    end

    assign tx        = r_tx;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign status    = {r_sticky, w_full, (r_count >= CNT_HALF), w_not_empty};

endmodule
